// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the multiplier_4bit / product_accumulator MAC path.
//   PROD_W  : width of the multiplier PRODUCT stream
//   ACC_W   : width of the accumulator and batch sum
//   state_e : two-state accumulator control (ACCUM collects, HOLD presents)
// ---------------------------------------------------------------------------
package mult_pkg;

   localparam int PROD_W = 8;
   localparam int ACC_W  = 12;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

endpackage : mult_pkg

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
// Accumulates a batch of unsigned products arriving on a valid/ready stream
// and presents the batch sum, term count and overflow flag on an output
// valid/ready stream. The last term of a batch is marked by in_last.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   product is valid this cycle
//   in_ready    out  block accepts a product this cycle (registered)
//   product     in   [PROD_W] unsigned product
//   in_last     in   product is the final term of the batch
//   out_valid   out  sum / term_count / overflow are valid
//   out_ready   in   downstream accepts the result
//   sum         out  [ACC_W] batch sum modulo 2^ACC_W
//   term_count  out  [CNT_W] terms in the batch, saturating
//   overflow    out  sticky: batch sum exceeded 2^ACC_W-1
// ---------------------------------------------------------------------------
module product_accumulator #(
   parameter int PROD_W = mult_pkg::PROD_W,
   parameter int ACC_W  = mult_pkg::ACC_W,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] product,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  sum,
   output logic [CNT_W-1:0]  term_count,
   output logic              overflow
);

   import mult_pkg::*;

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [ACC_W-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   term_count_q, term_count_d;
   logic               overflow_q, overflow_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;

   logic               accept;
   logic [ACC_W:0]     add_full;
   logic [CNT_W-1:0]   cnt_inc;

   assign accept = in_valid && in_ready_q;

   // One extra bit on the adder captures the carry that sets the sticky flag.
   assign add_full = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
   assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      // NOTE: every variable gets a hold default first so no path leaves it
      // unassigned; that is what keeps this block from inferring latches.
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      ovf_d        = ovf_q;
      sum_d        = sum_q;
      term_count_d = term_count_q;
      overflow_d   = overflow_q;
      out_valid_d  = out_valid_q;

      case (state_q)
         ACCUM: begin
            // product is only looked at under accept, so X on an idle bus
            // never reaches a register.
            if (accept) begin
               acc_d = add_full[ACC_W-1:0];
               ovf_d = ovf_q | add_full[ACC_W];
               cnt_d = cnt_inc;
               if (in_last) begin
                  sum_d        = add_full[ACC_W-1:0];
                  term_count_d = cnt_inc;
                  overflow_d   = ovf_q | add_full[ACC_W];
                  out_valid_d  = 1'b1;
                  state_d      = HOLD;
               end
            end
         end
         HOLD: begin
            // Result registers keep their values past the handshake; only
            // the running accumulator is cleared for the next batch.
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               acc_d       = '0;
               cnt_d       = '0;
               ovf_d       = 1'b0;
               state_d     = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase

      // Registered ready follows the next state, which also makes it rise on
      // the first edge after reset and one cycle after the output handshake,
      // guaranteeing an idle cycle between batches.
      in_ready_d = (state_d == ACCUM);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values computed above regardless of block order.
   // NOTE: all flops, including the result registers, are reset; a reset
   // mid-batch or in HOLD must discard everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ACCUM;
         acc_q        <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         sum_q        <= '0;
         term_count_q <= '0;
         overflow_q   <= 1'b0;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         sum_q        <= sum_d;
         term_count_q <= term_count_d;
         overflow_q   <= overflow_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign sum        = sum_q;
   assign term_count = term_count_q;
   assign overflow   = overflow_q;

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
// Directed stimulus for product_accumulator. A batch-level model (running
// integer total, term count, handshake flags) predicts every output; a
// compare process checks it each falling edge, and the directed sequence
// pins hand-computed results.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

   localparam int PROD_W = 8;
   localparam int ACC_W  = 12;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] product;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  sum;
   logic [CNT_W-1:0]  term_count;
   logic              overflow;

   int tests_run;
   int tests_failed;

   product_accumulator #(
      .PROD_W(PROD_W),
      .ACC_W (ACC_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .product   (product),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .term_count(term_count),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   // ---------------- batch-level model ----------------
   int m_total;
   int m_terms;
   int m_sum;
   int m_cnt;
   int m_ovf;
   bit m_out_valid;
   bit m_in_ready;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_total = 0; m_terms = 0;
         m_sum = 0; m_cnt = 0; m_ovf = 0;
         m_out_valid = 0; m_in_ready = 0;
      end else begin
         if (in_valid && m_in_ready) begin
            m_total += int'(product);
            m_terms += 1;
            if (in_last) begin
               m_sum = m_total % (1 << ACC_W);
               m_cnt = (m_terms > 15) ? 15 : m_terms;
               m_ovf = (m_total > (1 << ACC_W) - 1) ? 1 : 0;
               m_out_valid = 1;
               m_total = 0;
               m_terms = 0;
            end
         end else if (m_out_valid && out_ready) begin
            m_out_valid = 0;
         end
         // Ready whenever no result is pending, from the first edge after reset.
         m_in_ready = !m_out_valid;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("cmp_in_ready",   32'(in_ready),   32'(m_in_ready));
         check("cmp_out_valid",  32'(out_valid),  32'(m_out_valid));
         check("cmp_sum",        32'(sum),        32'(m_sum));
         check("cmp_term_count", 32'(term_count), 32'(m_cnt));
         check("cmp_overflow",   32'(overflow),   32'(m_ovf));
      end
   end

   always @(posedge clk) begin
      if (rst_n && ($isunknown(in_valid) || $isunknown(out_ready))) begin
         tests_failed++;
         $display("FAIL x_on_handshake: in_valid=%b out_ready=%b required known", in_valid, out_ready);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [PROD_W-1:0] p, input logic l);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      product  = p;
      in_last  = l;
      for (int k = 0; k < 20 && !done; k++) begin
         done = in_ready;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1 within 20 cycles");
      end
      in_valid = 1'b0;
      product  = 'x;
      in_last  = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_result(input string tag, input int s, input int c, input int o);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_sum"},       32'(sum),       32'(s));
      check({tag, "_count"},     32'(term_count), 32'(c));
      check({tag, "_overflow"},  32'(overflow),  32'(o));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1);
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      product   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Reset release
      tick(2);
      check("rst_in_ready",   32'(in_ready),   32'd0);
      check("rst_out_valid",  32'(out_valid),  32'd0);
      check("rst_sum",        32'(sum),        32'd0);
      check("rst_count",      32'(term_count), 32'd0);
      check("rst_overflow",   32'(overflow),   32'd0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready_low", 32'(in_ready), 32'd0);
      tick(1);
      check("rel_in_ready_high", 32'(in_ready), 32'd1);

      // Basic batch: 6 + 7 + 9
      send(8'd6, 1'b0);
      send(8'd7, 1'b0);
      send(8'd9, 1'b1);
      check_result("basic", 22, 3, 0);
      check("basic_busy", 32'(in_ready), 32'd0);
      tick(1);
      check("basic_done_valid", 32'(out_valid), 32'd0);
      check("basic_done_ready", 32'(in_ready),  32'd1);
      check("basic_sum_kept",   32'(sum),       32'd22);

      // Backpressure on a single-term batch
      out_ready = 1'b0;
      send(8'd225, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check_result("bp", 225, 1, 0);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         tick(1);
      end
      out_ready = 1'b1;
      tick(1);
      check("bp_done_valid", 32'(out_valid), 32'd0);
      check("bp_done_ready", 32'(in_ready),  32'd1);

      // Overflow and count saturation: 17 x 255 = 4335
      for (int i = 0; i < 16; i++) send(8'd255, 1'b0);
      send(8'd255, 1'b1);
      check_result("ovf", 239, 15, 1);
      tick(1);

      // Bubbles, with a stray in_last while in_valid is low
      send(8'd4, 1'b0);
      in_last = 1'b1;
      tick(3);
      in_last = 1'b0;
      check("bubble_no_result", 32'(out_valid), 32'd0);
      send(8'd5, 1'b1);
      check_result("bubble", 9, 2, 0);
      tick(1);

      // Reset mid-batch
      send(8'd10, 1'b0);
      send(8'd20, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_sum",      32'(sum),      32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      send(8'd3, 1'b1);
      check_result("after_rst", 3, 1, 0);
      tick(1);

      // Reset during HOLD
      out_ready = 1'b0;
      send(8'd7, 1'b1);
      check_result("hold", 7, 1, 0);
      rst_n = 1'b0;
      #1;
      check("holdrst_out_valid", 32'(out_valid), 32'd0);
      check("holdrst_sum",       32'(sum),       32'd0);
      tick(2);
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick(2);
      check("final_in_ready", 32'(in_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_product_accumulator
